// File: rtl/gpu_ram_arbiter.sv
// Fixed-priority core/host arbiter in front of a single-port BlockRam.
// Optional host anti-starvation guard: define GPU_RAM_ARBITER_STARVE_GUARD_EN.
module gpu_ram_arbiter #(
  parameter int ADDRESS_WIDTH = 16,
  parameter int WORD_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     core_req_i,
  input  logic                     core_write_i,
  input  logic [ADDRESS_WIDTH-1:0] core_address_i,
  input  logic [WORD_WIDTH-1:0]    core_in_data_i,
  output logic                     core_grant_o,
  output logic                     core_valid_o,
  output logic [WORD_WIDTH-1:0]    core_out_data_o,
  input  logic                     host_req_i,
  input  logic                     host_write_i,
  input  logic [ADDRESS_WIDTH-1:0] host_address_i,
  input  logic [WORD_WIDTH-1:0]    host_in_data_i,
  output logic                     host_grant_o,
  output logic                     host_valid_o,
  output logic [WORD_WIDTH-1:0]    host_out_data_o,
  output logic [ADDRESS_WIDTH-1:0] ram_address_o,
  output logic                     ram_write_o,
  output logic [WORD_WIDTH-1:0]    ram_in_data_o,
  input  logic [WORD_WIDTH-1:0]    ram_out_data_i
);

  typedef enum logic [1:0] {SEL_NONE, SEL_CORE, SEL_HOST} sel_e;

  sel_e                  sel;
  logic                  forceHost;
  logic                  pendRead_q, pendRead_d;
  logic                  pendHost_q, pendHost_d;
  logic [WORD_WIDTH-1:0] coreData_q;
  logic [WORD_WIDTH-1:0] hostData_q;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : gLimitCheck
    $error("gpu_ram_arbiter: STARVE_LIMIT must be in 1..255");
  end

`ifdef GPU_RAM_ARBITER_STARVE_GUARD_EN
  logic [7:0] starveCnt_q, starveCnt_d;

  assign forceHost = host_req_i && (starveCnt_q >= 8'(STARVE_LIMIT));

  // Counts host wait cycles; a forced host slot clears it so core priority returns.
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!host_req_i || sel == SEL_HOST) begin
      starveCnt_d = 8'd0;
    end else if (starveCnt_q != 8'hFF) begin
      starveCnt_d = starveCnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      starveCnt_q <= 8'd0;
    end else begin
      starveCnt_q <= starveCnt_d;
    end
  end
`else
  assign forceHost = 1'b0;
`endif

  always_comb begin
    sel = SEL_NONE;
    if (reset_i) begin
      sel = SEL_NONE;
    end else if (forceHost) begin
      sel = SEL_HOST;
    end else if (core_req_i) begin
      sel = SEL_CORE;
    end else if (host_req_i) begin
      sel = SEL_HOST;
    end
  end

  assign core_grant_o = (sel == SEL_CORE);
  assign host_grant_o = (sel == SEL_HOST);

  always_comb begin
    ram_address_o = '0;
    ram_write_o   = 1'b0;
    ram_in_data_o = '0;
    pendRead_d    = 1'b0;
    pendHost_d    = 1'b0;
    case (sel)
      SEL_CORE: begin
        ram_address_o = core_address_i;
        ram_write_o   = core_write_i;
        ram_in_data_o = core_in_data_i;
        pendRead_d    = !core_write_i;
      end
      SEL_HOST: begin
        ram_address_o = host_address_i;
        ram_write_o   = host_write_i;
        ram_in_data_o = host_in_data_i;
        pendRead_d    = !host_write_i;
        pendHost_d    = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      pendRead_q <= 1'b0;
      pendHost_q <= 1'b0;
    end else begin
      pendRead_q <= pendRead_d;
      pendHost_q <= pendHost_d;
    end
  end

  // RAM data is live in the cycle after the grant; a reset in that cycle drops the pulse.
  assign core_valid_o = pendRead_q && !pendHost_q && !reset_i;
  assign host_valid_o = pendRead_q &&  pendHost_q && !reset_i;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      coreData_q <= '0;
      hostData_q <= '0;
    end else begin
      if (core_valid_o) coreData_q <= ram_out_data_i;
      if (host_valid_o) hostData_q <= ram_out_data_i;
    end
  end

  assign core_out_data_o = core_valid_o ? ram_out_data_i : coreData_q;
  assign host_out_data_o = host_valid_o ? ram_out_data_i : hostData_q;

endmodule
